// File: rtl/vga_timing_gen_if.sv
// Raster output bundle from the VGA timing generator to the DAC/TFT path and
// the framebuffer reader.
interface vga_timing_gen_if #(
    parameter int CW = 10,
    parameter int AW = 17
);
    logic          clkout;
    logic          Hsync;
    logic          Vsync;
    logic          Nblank;
    logic          Nsync;
    logic          activeArea;
    logic [CW-1:0] pixel_x;
    logic [CW-1:0] pixel_y;
    logic          frame_start;
    logic          line_start;
    logic [AW-1:0] rd_addr;

    modport master (
        output clkout, Hsync, Vsync, Nblank, Nsync, activeArea,
               pixel_x, pixel_y, frame_start, line_start, rd_addr
    );
    modport slave (
        input  clkout, Hsync, Vsync, Nblank, Nsync, activeArea,
               pixel_x, pixel_y, frame_start, line_start, rd_addr
    );
endinterface

// File: rtl/vga_timing_gen.sv
// Programmable VGA raster timing with a window-qualified framebuffer read
// address and optional 2x pixel/line replication. Every output is registered.
module vga_timing_gen #(
    parameter int CW        = 10,
    parameter int AW        = 17,
    parameter int HD        = 640,
    parameter int HF        = 16,
    parameter int HR        = 96,
    parameter int HB        = 48,
    parameter int VD        = 480,
    parameter int VF        = 10,
    parameter int VR        = 2,
    parameter int VB        = 33,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0,
    parameter int WIN_X0    = 0,
    parameter int WIN_Y0    = 0,
    parameter int WIN_W     = 320,
    parameter int WIN_H     = 240,
    parameter int SCALE     = 1
) (
    input  logic              CLK25,
    input  logic              Nreset,
    vga_timing_gen_if.master  vga
);
    localparam int HT  = HD + HF + HR + HB;
    localparam int VT  = VD + VF + VR + VB;
    localparam int XE  = WIN_X0 + WIN_W * SCALE;
    localparam int YE  = WIN_Y0 + WIN_H * SCALE;
    localparam bit REP = (SCALE == 2);

    if (SCALE != 1 && SCALE != 2) begin : g_bad_scale
        $error("vga_timing_gen: SCALE must be 1 or 2");
    end
    if (XE > HD) begin : g_bad_win_x
        $error("vga_timing_gen: window exceeds active width");
    end
    if (YE > VD) begin : g_bad_win_y
        $error("vga_timing_gen: window exceeds active height");
    end
    if (WIN_W * WIN_H > (1 << AW)) begin : g_bad_aw
        $error("vga_timing_gen: window does not fit in AW address bits");
    end
    if (HT > (1 << CW) || VT > (1 << CW)) begin : g_bad_cw
        $error("vga_timing_gen: raster totals do not fit in CW bits");
    end

    logic [CW-1:0] r_hcnt, r_vcnt;
    logic          w_hlast, w_vlast, w_origin, w_hs_on, w_vs_on;
    logic          w_nblank, w_win, w_win_eol;

    assign w_hlast   = (r_hcnt == CW'(HT - 1));
    assign w_vlast   = (r_vcnt == CW'(VT - 1));
    assign w_origin  = (r_hcnt == '0) && (r_vcnt == '0);
    assign w_hs_on   = (r_hcnt >= CW'(HD + HF)) && (r_hcnt <= CW'(HD + HF + HR - 1));
    assign w_vs_on   = (r_vcnt >= CW'(VD + VF)) && (r_vcnt <= CW'(VD + VF + VR - 1));
    assign w_nblank  = (r_hcnt < CW'(HD)) && (r_vcnt < CW'(VD));
    assign w_win     = (r_hcnt >= CW'(WIN_X0)) && (r_hcnt < CW'(XE)) &&
                       (r_vcnt >= CW'(WIN_Y0)) && (r_vcnt < CW'(YE));
    assign w_win_eol = w_win && (r_hcnt == CW'(XE - 1));

    always_ff @(posedge CLK25 or negedge Nreset) begin
        if (!Nreset) begin
            r_hcnt <= '0;
            r_vcnt <= '0;
        end else if (w_hlast) begin
            r_hcnt <= '0;
            r_vcnt <= w_vlast ? '0 : r_vcnt + 1'b1;
        end else begin
            r_hcnt <= r_hcnt + 1'b1;
        end
    end

    // r_addr is the address of the window pixel at the current counter
    // position; sub-counters hold it for SCALE pixels and rewind once per line.
    logic [AW-1:0] r_addr, r_line_base;
    logic          r_hsub, r_vsub;

    always_ff @(posedge CLK25 or negedge Nreset) begin
        if (!Nreset) begin
            r_addr      <= '0;
            r_line_base <= '0;
            r_hsub      <= 1'b0;
            r_vsub      <= 1'b0;
        end else if (w_hlast && w_vlast) begin
            r_addr      <= '0;
            r_line_base <= '0;
            r_hsub      <= 1'b0;
            r_vsub      <= 1'b0;
        end else if (w_win) begin
            if (w_win_eol) begin
                r_hsub <= 1'b0;
                if (REP && !r_vsub) begin
                    r_addr <= r_line_base;
                    r_vsub <= 1'b1;
                end else begin
                    r_addr      <= r_addr + 1'b1;
                    r_line_base <= r_addr + 1'b1;
                    r_vsub      <= 1'b0;
                end
            end else if (REP && !r_hsub) begin
                r_hsub <= 1'b1;
            end else begin
                r_hsub <= 1'b0;
                r_addr <= r_addr + 1'b1;
            end
        end
    end

    logic          r_hsync, r_vsync, r_nblank, r_active, r_fs, r_ls;
    logic [CW-1:0] r_px, r_py;
    logic [AW-1:0] r_rd_addr;

    always_ff @(posedge CLK25 or negedge Nreset) begin
        if (!Nreset) begin
            r_hsync   <= ~HSYNC_POL;
            r_vsync   <= ~VSYNC_POL;
            r_nblank  <= 1'b0;
            r_active  <= 1'b0;
            r_fs      <= 1'b0;
            r_ls      <= 1'b0;
            r_px      <= '0;
            r_py      <= '0;
            r_rd_addr <= '0;
        end else begin
            r_hsync  <= w_hs_on ? HSYNC_POL : ~HSYNC_POL;
            r_vsync  <= w_vs_on ? VSYNC_POL : ~VSYNC_POL;
            r_nblank <= w_nblank;
            r_active <= w_win;
            r_fs     <= w_origin;
            r_ls     <= (r_hcnt == '0);
            r_px     <= r_hcnt;
            r_py     <= r_vcnt;
            if (w_win)
                r_rd_addr <= r_addr;
            else if (w_origin)
                r_rd_addr <= '0;
        end
    end

    assign vga.clkout      = CLK25;
    assign vga.Nsync       = 1'b1;
    assign vga.Hsync       = r_hsync;
    assign vga.Vsync       = r_vsync;
    assign vga.Nblank      = r_nblank;
    assign vga.activeArea  = r_active;
    assign vga.pixel_x     = r_px;
    assign vga.pixel_y     = r_py;
    assign vga.frame_start = r_fs;
    assign vga.line_start  = r_ls;
    assign vga.rd_addr     = r_rd_addr;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Two reduced-geometry instances (offset SCALE=1 window, full-screen SCALE=2
// window with inverted sync polarity) checked cycle by cycle via a scoreboard.
module tb_vga_timing_gen;
    localparam int HD = 40, HF = 4, HR = 6, HB = 10;
    localparam int VD = 30, VF = 2, VR = 2, VB = 4;
    localparam int HT = HD + HF + HR + HB;
    localparam int VT = VD + VF + VR + VB;
    localparam int FRAME = HT * VT;

    typedef struct packed {
        logic        clkout;
        logic        nsync;
        logic        hs;
        logic        vs;
        logic        nb;
        logic        act;
        logic        fs;
        logic        ls;
        logic [9:0]  px;
        logic [9:0]  py;
        logic [16:0] addr;
    } obs_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    vga_timing_gen_if #(.CW(10), .AW(17)) vif0 ();
    vga_timing_gen_if #(.CW(10), .AW(17)) vif1 ();

    vga_timing_gen #(
        .CW(10), .AW(17), .HD(HD), .HF(HF), .HR(HR), .HB(HB),
        .VD(VD), .VF(VF), .VR(VR), .VB(VB), .HSYNC_POL(1'b0), .VSYNC_POL(1'b0),
        .WIN_X0(5), .WIN_Y0(2), .WIN_W(20), .WIN_H(15), .SCALE(1)
    ) u_dut0 (.CLK25(clk), .Nreset(rst_n), .vga(vif0));

    vga_timing_gen #(
        .CW(10), .AW(17), .HD(HD), .HF(HF), .HR(HR), .HB(HB),
        .VD(VD), .VF(VF), .VR(VR), .VB(VB), .HSYNC_POL(1'b1), .VSYNC_POL(1'b1),
        .WIN_X0(0), .WIN_Y0(0), .WIN_W(20), .WIN_H(15), .SCALE(2)
    ) u_dut1 (.CLK25(clk), .Nreset(rst_n), .vga(vif1));

    obs_t q0[$], q1[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   mh = 0, mv = 0;
    int   last0 = 0, last1 = 0;

    function automatic obs_t reset_obs(input bit pol);
        obs_t o;
        o = '0;
        o.nsync = 1'b1;
        o.hs    = ~pol;
        o.vs    = ~pol;
        return o;
    endfunction

    // Reference: outputs for raster position (h,v) straight from the formulas.
    function automatic obs_t model(input int h, input int v, input bit pol,
                                   input int x0, input int y0, input int w,
                                   input int hh, input int s, input int last);
        obs_t o;
        o        = '0;
        o.nsync  = 1'b1;
        o.hs     = (h >= HD + HF && h < HD + HF + HR) ? pol : ~pol;
        o.vs     = (v >= VD + VF && v < VD + VF + VR) ? pol : ~pol;
        o.nb     = (h < HD) && (v < VD);
        o.act    = (h >= x0) && (h < x0 + w * s) && (v >= y0) && (v < y0 + hh * s);
        o.fs     = (h == 0) && (v == 0);
        o.ls     = (h == 0);
        o.px     = 10'(h);
        o.py     = 10'(v);
        if (o.act)
            o.addr = 17'(((v - y0) / s) * w + (h - x0) / s);
        else if (o.fs)
            o.addr = '0;
        else
            o.addr = 17'(last);
        return o;
    endfunction

    // Driver side of the scoreboard: predicts what each edge should present.
    initial begin : driver
        logic rst_edge;
        obs_t e0, e1;
        forever begin
            @(posedge clk);
            rst_edge = rst_n;
            #3;
            if (!rst_n || !rst_edge) begin
                mh = 0; mv = 0; last0 = 0; last1 = 0;
                q0.push_back(reset_obs(1'b0));
                q1.push_back(reset_obs(1'b1));
            end else begin
                e0 = model(mh, mv, 1'b0, 5, 2, 20, 15, 1, last0);
                e1 = model(mh, mv, 1'b1, 0, 0, 20, 15, 2, last1);
                last0 = int'(e0.addr);
                last1 = int'(e1.addr);
                q0.push_back(e0);
                q1.push_back(e1);
                mh++;
                if (mh == HT) begin
                    mh = 0;
                    mv = (mv == VT - 1) ? 0 : mv + 1;
                end
            end
        end
    end

    // Monitor: samples on the falling edge, pops and compares.
    always @(negedge clk) begin
        obs_t a, e;
        if (q0.size() > 0) begin
            e = q0.pop_front();
            a = '{clkout: vif0.clkout, nsync: vif0.Nsync, hs: vif0.Hsync, vs: vif0.Vsync,
                  nb: vif0.Nblank, act: vif0.activeArea, fs: vif0.frame_start,
                  ls: vif0.line_start, px: vif0.pixel_x, py: vif0.pixel_y, addr: vif0.rd_addr};
            n_checks++;
            if (a === e) n_pass++;
            else $display("FAIL dut0_outputs t=%0t got=%h expected=%h (x=%0d y=%0d addr=%0d vs %0d)",
                          $time, a, e, a.px, a.py, a.addr, e.addr);
        end
        if (q1.size() > 0) begin
            e = q1.pop_front();
            a = '{clkout: vif1.clkout, nsync: vif1.Nsync, hs: vif1.Hsync, vs: vif1.Vsync,
                  nb: vif1.Nblank, act: vif1.activeArea, fs: vif1.frame_start,
                  ls: vif1.line_start, px: vif1.pixel_x, py: vif1.pixel_y, addr: vif1.rd_addr};
            n_checks++;
            if (a === e) n_pass++;
            else $display("FAIL dut1_outputs t=%0t got=%h expected=%h (x=%0d y=%0d addr=%0d vs %0d)",
                          $time, a, e, a.px, a.py, a.addr, e.addr);
        end
    end

    initial begin : stimulus
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (2 * FRAME + 100) @(posedge clk);
        for (int k = 0; k < 5; k++) begin
            repeat ($urandom_range(100, 3000)) @(posedge clk);
            #2 rst_n = 1'b0;
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #2 rst_n = 1'b1;
        end
        repeat (2 * FRAME + 50) @(posedge clk);
        #6;
        n_checks++;
        if (q0.size() == 0 && q1.size() == 0) n_pass++;
        else $display("FAIL scoreboard_drain left=%0d/%0d required=0", q0.size(), q1.size());
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
